// File: rtl/demodulator_psk_if.sv
// ============================================================================
// Module   : demodulator_psk_if
// Purpose  : FIFO write-side bundle between the PSK demodulator and the RX
//            sample FIFO.
// Signals  : write - one-cycle FIFO write strobe (demodulator -> FIFO)
//            data  - 8-bit left-aligned symbol  (demodulator -> FIFO)
//            full  - FIFO full                  (FIFO -> demodulator)
// Modports : master - demodulator side; slave - FIFO side
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface demodulator_psk_if;
  logic       write;
  logic [7:0] data;
  logic       full;

  modport master (output write, output data, input full);
  modport slave  (input write, input data, output full);
endinterface

`default_nettype wire

// File: rtl/demodulator_psk.sv
// ============================================================================
// Module   : demodulator_psk
// Purpose  : Receive side of the serial PSK symbol link. Synchronises the
//            serial line, waits for a low idle run, frames on a start-bit
//            rising edge, assembles PSK_BITS_PER_SYMBOL bits per symbol
//            (MSB first, left-aligned in a byte) and writes each symbol to
//            the downstream FIFO.
// Ports    : clk      - system clock, rising edge
//            rst_n    - asynchronous active-low reset
//            enable   - 1 = run, 0 = force idle and clear counters
//            din      - serial line, asynchronous to clk
//            fifo     - demodulator_psk_if.master (write/data out, full in)
//            busy     - 1 while a frame is being received
//            overflow - sticky flag: a symbol was dropped on full
//            clr_ovf  - synchronous clear of overflow (a same-cycle set wins)
// Options  : DEMOD_EDGE_RESYNC_EN - when defined, every line edge seen during
//            a frame re-aligns the bit timing; when undefined, the timing is
//            fixed by the start edge and free-runs for the whole frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demodulator_psk #(
  parameter int PSK_CLKS_PER_BIT    = 4,
  parameter int PSK_BITS_PER_SYMBOL = 4,
  parameter int FRAME_SYMBOLS       = 16,
  parameter int IDLE_BITS           = 2
) (
  input  wire                      clk,
  input  wire                      rst_n,
  input  wire                      enable,
  input  wire                      din,
  input  wire                      clr_ovf,
  demodulator_psk_if.master        fifo,
  output logic                     busy,
  output logic                     overflow
);

  localparam int IDLE_TARGET = IDLE_BITS * PSK_CLKS_PER_BIT;
  localparam int LOW_W = ($clog2(IDLE_TARGET + 1) < 1) ? 1 : $clog2(IDLE_TARGET + 1);
  localparam int CLK_W = ($clog2(PSK_CLKS_PER_BIT) < 1) ? 1 : $clog2(PSK_CLKS_PER_BIT);
  localparam int BIT_W = ($clog2(PSK_BITS_PER_SYMBOL) < 1) ? 1 : $clog2(PSK_BITS_PER_SYMBOL);
  localparam int SYM_W = ($clog2(FRAME_SYMBOLS) < 1) ? 1 : $clog2(FRAME_SYMBOLS);

  localparam logic [LOW_W-1:0] LOW_LAST = LOW_W'(IDLE_TARGET - 1);
  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(PSK_CLKS_PER_BIT - 1);
  localparam logic [CLK_W-1:0] CLK_HALF = CLK_W'(PSK_CLKS_PER_BIT / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PSK_BITS_PER_SYMBOL - 1);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(FRAME_SYMBOLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             ds_dly_q, ds_dly_d;
  logic [LOW_W-1:0] low_cnt_q, low_cnt_d;
  logic [CLK_W-1:0] clks_q, clks_d;
  logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
  logic [SYM_W-1:0] sym_cnt_q, sym_cnt_d;
  logic             skip_q, skip_d;
  logic [7:0]       sym_q, sym_d;
  logic             write_q, write_d;
  logic [7:0]       data_q, data_d;
  logic             overflow_q, overflow_d;

  logic             ds;
  logic             rise;
  logic             step;
  logic [2:0]       bit_pos;
  logic [7:0]       sym_next;

  assign ds   = sync2_q;
  assign rise = sync2_q & ~ds_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      ds_dly_q   <= 1'b0;
      low_cnt_q  <= '0;
      clks_q     <= '0;
      bit_idx_q  <= '0;
      sym_cnt_q  <= '0;
      skip_q     <= 1'b0;
      sym_q      <= '0;
      write_q    <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      ds_dly_q   <= ds_dly_d;
      low_cnt_q  <= low_cnt_d;
      clks_q     <= clks_d;
      bit_idx_q  <= bit_idx_d;
      sym_cnt_q  <= sym_cnt_d;
      skip_q     <= skip_d;
      sym_q      <= sym_d;
      write_q    <= write_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    sync1_d    = din;
    sync2_d    = sync1_q;
    ds_dly_d   = sync2_q;
    state_d    = state_q;
    low_cnt_d  = low_cnt_q;
    clks_d     = clks_q;
    bit_idx_d  = bit_idx_q;
    sym_cnt_d  = sym_cnt_q;
    skip_d     = skip_q;
    sym_d      = sym_q;
    write_d    = 1'b0;
    data_d     = data_q;
    overflow_d = overflow_q;
    step       = 1'b0;
    bit_pos    = 3'd7 - 3'(bit_idx_q);
    sym_next   = sym_q;

    // Clear first so that an overflow event below in the same cycle wins.
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end

    if (!enable) begin
      state_d   = ST_IDLE;
      low_cnt_d = '0;
      clks_d    = '0;
      bit_idx_d = '0;
      sym_cnt_d = '0;
      skip_d    = 1'b0;
      sym_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ds) begin
            low_cnt_d = '0;
          end else if (low_cnt_q == LOW_LAST) begin
            low_cnt_d = '0;
            state_d   = ST_HUNT;
          end else begin
            low_cnt_d = low_cnt_q + 1'b1;
          end
        end

        ST_HUNT: begin
          if (rise) begin
            clks_d    = '0;
            bit_idx_d = '0;
            skip_d    = 1'b1;
            sym_d     = '0;
            state_d   = ST_RUN;
          end
        end

        ST_RUN: begin
          step   = (clks_q == CLK_LAST);
          clks_d = step ? '0 : clks_q + 1'b1;

`ifdef DEMOD_EDGE_RESYNC_EN
          // An edge is a bit boundary. Past the sample point the boundary
          // came early, so finish the current bit now; at or before it the
          // boundary came late, so only restart the bit timing.
          if ((sync2_q ^ ds_dly_q) && (clks_q != '0)) begin
            clks_d = '0;
            if (clks_q > CLK_HALF) begin
              step = 1'b1;
            end
          end
`endif

          // The bit index wraps modulo the symbol length, so it already
          // reads zero when the first bit of the next symbol begins.
          if (step) begin
            if (skip_q) begin
              skip_d = 1'b0;
            end else if (bit_idx_q == BIT_LAST) begin
              bit_idx_d = '0;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end

          if ((clks_q == CLK_HALF) && !skip_q) begin
            sym_next          = sym_q;
            sym_next[bit_pos] = ds;
            if (bit_idx_q == BIT_LAST) begin
              sym_d = '0;
              if (fifo.full) begin
                overflow_d = 1'b1;
              end else begin
                write_d = 1'b1;
                data_d  = sym_next;
              end
              if (sym_cnt_q == SYM_LAST) begin
                state_d   = ST_IDLE;
                sym_cnt_d = '0;
                clks_d    = '0;
                bit_idx_d = '0;
                skip_d    = 1'b0;
              end else begin
                sym_cnt_d = sym_cnt_q + 1'b1;
              end
            end else begin
              sym_d = sym_next;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign fifo.write = write_q;
  assign fifo.data  = data_q;
  assign busy       = (state_q == ST_RUN);
  assign overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_demodulator_psk.sv
// ============================================================================
// Module   : tb_demodulator_psk
// Purpose  : Directed self-checking bench for demodulator_psk
//            (CLKS=4, BITS=4, FRAME=2, IDLE=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demodulator_psk;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic din;
  logic clr_ovf;
  logic busy;
  logic overflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] got[$];

  demodulator_psk_if fifo_if ();

  demodulator_psk #(
    .PSK_CLKS_PER_BIT    (4),
    .PSK_BITS_PER_SYMBOL (4),
    .FRAME_SYMBOLS       (2),
    .IDLE_BITS           (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .din      (din),
    .clr_ovf  (clr_ovf),
    .fifo     (fifo_if),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Record every FIFO write, sampled away from the active edge.
  always @(negedge clk) begin
    if (fifo_if.write) got.push_back(fifo_if.data);
  end

  function automatic logic [7:0] got_at(input int i);
    logic [7:0] v;
    v = 8'hxx;
    if (i < got.size()) v = got[i];
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v, input int per);
    din = v;
    cycles(per);
  endtask

  // Start bit, then 8 data bits MSB first; optionally raise full from bit 5.
  task automatic send_frame(input logic [7:0] bits, input int per, input bit full_sym1);
    send_bit(1'b1, per);
    for (int i = 0; i < 8; i++) begin
      if (full_sym1 && i == 5) fifo_if.full = 1'b1;
      send_bit(bits[7-i], per);
    end
    din = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b1;
    din          = 1'b0;
    clr_ovf      = 1'b0;
    fifo_if.full = 1'b0;
    cycles(3);
    check("reset_write", 32'(fifo_if.write), 32'h0);
    check("reset_data",  32'(fifo_if.data),  32'h0);
    check("reset_busy",  32'(busy),          32'h0);
    check("reset_ovf",   32'(overflow),      32'h0);
    rst_n = 1'b1;

    // 1: basic frame
    cycles(32);
    got.delete();
    send_frame(8'hA6, 4, 1'b0);
    cycles(8);
    check("t1_count", 32'(got.size()), 32'd2);
    check("t1_sym0",  32'(got_at(0)), 32'hA0);
    check("t1_sym1",  32'(got_at(1)), 32'h60);
    check("t1_busy",  32'(busy),      32'h0);
    check("t1_ovf",   32'(overflow),  32'h0);

    // 2: full during the second symbol
    cycles(32);
    got.delete();
    send_frame(8'hA6, 4, 1'b1);
    cycles(8);
    fifo_if.full = 1'b0;
    check("t2_count", 32'(got.size()),   32'd1);
    check("t2_sym0",  32'(got_at(0)),    32'hA0);
    check("t2_ovf",   32'(overflow),     32'h1);
    check("t2_hold",  32'(fifo_if.data), 32'hA0);
    clr_ovf = 1'b1;
    cycles(1);
    clr_ovf = 1'b0;
    check("t2_clr",   32'(overflow),     32'h0);

    // 3: line high from reset, edge without a low run is ignored
    rst_n = 1'b0;
    din   = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(20);
    got.delete();
    din = 1'b0;
    cycles(3);
    send_frame(8'hAA, 4, 1'b0);
    cycles(8);
    check("t3_nowrite", 32'(got.size()), 32'd0);
    cycles(32);
    send_frame(8'hA6, 4, 1'b0);
    cycles(8);
    check("t3_count", 32'(got.size()), 32'd2);
    check("t3_sym0",  32'(got_at(0)), 32'hA0);
    check("t3_sym1",  32'(got_at(1)), 32'h60);

    // 4: enable dropped after two data bits
    cycles(32);
    got.delete();
    send_bit(1'b1, 4);
    send_bit(1'b1, 4);
    send_bit(1'b0, 4);
    check("t4_busy_run", 32'(busy), 32'h1);
    enable = 1'b0;
    din    = 1'b0;
    cycles(2);
    check("t4_busy_off", 32'(busy), 32'h0);
    cycles(30);
    check("t4_nowrite", 32'(got.size()), 32'd0);
    enable = 1'b1;
    cycles(32);
    send_frame(8'hA6, 4, 1'b0);
    cycles(8);
    check("t4_count", 32'(got.size()), 32'd2);
    check("t4_sym0",  32'(got_at(0)), 32'hA0);
    check("t4_sym1",  32'(got_at(1)), 32'h60);

    // 5: asynchronous reset mid-symbol
    cycles(32);
    got.delete();
    send_bit(1'b1, 4);
    send_bit(1'b1, 4);
    send_bit(1'b0, 4);
    rst_n = 1'b0;
    #1;
    check("t5_write", 32'(fifo_if.write), 32'h0);
    check("t5_data",  32'(fifo_if.data),  32'h0);
    check("t5_busy",  32'(busy),          32'h0);
    check("t5_ovf",   32'(overflow),      32'h0);
    din = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(32);
    send_frame(8'hA6, 4, 1'b0);
    cycles(8);
    check("t5_count", 32'(got.size()), 32'd2);
    check("t5_sym0",  32'(got_at(0)), 32'hA0);
    check("t5_sym1",  32'(got_at(1)), 32'h60);

    // 6: bit period drifted to 5 cycles
    cycles(32);
    got.delete();
    send_frame(8'hA6, 5, 1'b0);
    cycles(10);
    check("t6_count", 32'(got.size()), 32'd2);
`ifdef DEMOD_EDGE_RESYNC_EN
    check("t6_sym0", 32'(got_at(0)), 32'hA0);
    check("t6_sym1", 32'(got_at(1)), 32'h60);
`else
    n_cmp++;
    assert (got_at(1) !== 8'h60) else begin
      n_bad++;
      $error("FAIL t6_sym1_drift: observed=%0h expected=not 60", got_at(1));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
